// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the run/pause/clear sequencer of the display counter.
package count_sequencer_pkg;

  // Sequencer states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

  // Counter value width.
  localparam int unsigned CNT_W = 8;

  // 20 ms of stable key level at 50 MHz.
  localparam int unsigned DB_CYCLES_DEF = 1_000_000;
  localparam int unsigned DB_W_DEF      = 20;

  // Full-width equality against the terminal count.
  function automatic logic is_terminal(input logic [CNT_W-1:0] data,
                                       input logic [CNT_W-1:0] term);
    return (data == term);
  endfunction

endpackage

// File: rtl/count_sequencer_key_debounce.sv
// Key conditioner: 2-flop synchronizer, debounce counter, accepted level and
// a one-cycle press pulse on each rising edge of the accepted level.
module key_debounce
  import count_sequencer_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned DB_W      = DB_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  // The counter runs 0..DB_CYCLES-1, so the level is accepted on the
  // DB_CYCLES-th consecutive cycle that the synchronized key disagrees.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic            level_p2;
  logic            level_d_p2;
  logic [DB_W-1:0] db_cnt;

  // Stage p0/p1: bring the raw key into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: accept a new level only after it has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_p2 <= 1'b0;
      db_cnt   <= '0;
    end else if (sync_p1 == level_p2) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      level_p2 <= sync_p1;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Stage p3: registered rising-edge detect; releases produce nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d_p2 <= 1'b0;
      press      <= 1'b0;
    end else begin
      level_d_p2 <= level_p2;
      press      <= level_p2 & ~level_d_p2;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/clear controller: conditions the two keys, sequences
// IDLE/RUN/PAUSE/DONE and gates the pulse-generator tick into cnt_en.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int unsigned      DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned      DB_W      = DB_W_DEF,
  parameter logic [CNT_W-1:0] TERMINAL  = 8'hFF,
  parameter bit               WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_run,
  input  logic             key_clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] cnt_data,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [1:0]       state,
  output logic             done
);

  logic       run_press;
  logic       clr_press;
  seq_state_t state_q;
  seq_state_t state_d;
  logic       cnt_en_d;
  logic       cnt_clr_d;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_key_run (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_run),
    .press (run_press)
  );

  key_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_key_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_clr),
    .press (clr_press)
  );

  // Next state and strobes; clear beats everything, a run press beats a tick.
  always_comb begin
    state_d   = state_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    if (clr_press) begin
      state_d   = ST_IDLE;
      cnt_clr_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_press) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (run_press) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (is_terminal(cnt_data, TERMINAL) && !WRAP) state_d = ST_DONE;
            else                                          cnt_en_d = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (run_press) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered counter strobes update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_en  <= cnt_en_d;
      cnt_clr <= cnt_clr_d;
    end
  end

  assign state = state_q;
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer with DB_CYCLES=4, TERMINAL=5, WRAP=0.
module tb_count_sequencer;

  localparam int DB = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       key_run  = 1'b0;
  logic       key_clr  = 1'b0;
  logic       tick     = 1'b0;
  logic [7:0] cnt_data = 8'h00;
  logic       cnt_en;
  logic       cnt_clr;
  logic [1:0] state;
  logic       done;

  count_sequencer #(
    .DB_CYCLES (DB),
    .DB_W      (4),
    .TERMINAL  (8'h05),
    .WRAP      (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_run  (key_run),
    .key_clr  (key_clr),
    .tick     (tick),
    .cnt_data (cnt_data),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .state    (state),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      tag;
    logic [4:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t mon_e;
  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [4:0] exp_vec(input logic [1:0] st, input logic en, input logic clr);
    return {st, (st == 2'b11), en, clr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int c, input string tag, input logic [1:0] st,
                           input logic en, input logic clr);
    sb_item_t e;
    e.cyc = c;
    e.tag = tag;
    e.exp = exp_vec(st, en, clr);
    sb.push_back(e);
  endtask

  // Monitor: pop every expectation due by this cycle and compare.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) chk({mon_e.tag, "_sched"}, 32'(cyc), 32'(mon_e.cyc));
      else chk(mon_e.tag, {27'b0, state, done, cnt_en, cnt_clr}, {27'b0, mon_e.exp});
    end
  end

  // One tick with the given counter value; called on a negedge.
  task automatic tick_once(input logic [7:0] d, input string tag,
                           input logic [1:0] st, input logic en);
    int t;
    t = cyc;
    expect_at(t + 1, tag, st, en, 1'b0);
    expect_at(t + 2, {tag, "_end"}, st, 1'b0, 1'b0);
    tick = 1'b1;
    cnt_data = d;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
  endtask

  // Clean key press (10 cycles) followed by release and settle time.
  // The press pulse lands after edge t0+DB+3, the new state after t0+DB+4.
  task automatic press(input bit r, input bit c, input bit with_tick, input string tag,
                       input logic [1:0] st_before, input logic [1:0] st_after,
                       input logic en_after);
    int t0;
    t0 = cyc;
    expect_at(t0 + DB + 3, {tag, "_pre"}, st_before, 1'b0, 1'b0);
    expect_at(t0 + DB + 4, tag, st_after, en_after, c);
    expect_at(t0 + DB + 5, {tag, "_post"}, st_after, 1'b0, 1'b0);
    key_run = r;
    key_clr = c;
    repeat (DB + 3) @(negedge clk);
    if (with_tick) begin
      tick = 1'b1;
      cnt_data = 8'h00;
    end
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    key_run = 1'b0;
    key_clr = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int t;
    int r;
    repeat (3) @(negedge clk);
    chk("reset_out", {27'b0, state, done, cnt_en, cnt_clr}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Bounce: 2-cycle toggles never survive the debounce window.
    t = cyc;
    for (int i = 1; i <= 32; i++) expect_at(t + i, "bounce", 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      key_run = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    key_run = 1'b0;
    repeat (14) @(negedge clk);

    // Run press, then ticks counted.
    press(1'b1, 1'b0, 1'b0, "run1", 2'b00, 2'b01, 1'b0);
    tick_once(8'h00, "tick_run", 2'b01, 1'b1);

    // Pause ignores ticks; a second press resumes.
    press(1'b1, 1'b0, 1'b0, "pause", 2'b01, 2'b10, 1'b0);
    for (int i = 0; i < 5; i++) tick_once(8'h01, "tick_pause", 2'b10, 1'b0);
    press(1'b1, 1'b0, 1'b0, "resume", 2'b10, 2'b01, 1'b0);
    tick_once(8'h02, "tick_resume", 2'b01, 1'b1);

    // Terminal count with WRAP=0.
    tick_once(8'h04, "tick_pre_term", 2'b01, 1'b1);
    tick_once(8'h05, "tick_term", 2'b11, 1'b0);
    tick_once(8'h03, "tick_done", 2'b11, 1'b0);
    press(1'b1, 1'b0, 1'b0, "run_in_done", 2'b11, 2'b11, 1'b0);
    press(1'b0, 1'b1, 1'b0, "clr_done", 2'b11, 2'b00, 1'b0);

    // Collisions.
    press(1'b1, 1'b0, 1'b0, "run2", 2'b00, 2'b01, 1'b0);
    press(1'b1, 1'b1, 1'b0, "run_clr", 2'b01, 2'b00, 1'b0);
    press(1'b1, 1'b0, 1'b0, "run3", 2'b00, 2'b01, 1'b0);
    press(1'b1, 1'b0, 1'b1, "run_tick", 2'b01, 2'b10, 1'b0);
    press(1'b1, 1'b0, 1'b0, "resume2", 2'b10, 2'b01, 1'b0);
    press(1'b0, 1'b1, 1'b1, "clr_tick", 2'b01, 2'b00, 1'b0);

    // Reset in the middle of a debounce with the key held.
    press(1'b1, 1'b0, 1'b0, "run4", 2'b00, 2'b01, 1'b0);
    key_run = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {27'b0, state, done, cnt_en, cnt_clr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    for (int i = 1; i <= DB + 3; i++) expect_at(r + i, "rst_wait", 2'b00, 1'b0, 1'b0);
    expect_at(r + DB + 4, "rst_press", 2'b01, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    key_run = 1'b0;
    repeat (12) @(negedge clk);

    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
